// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage with a one-entry skid buffer and a synchronous flush.
// Optional perf counters (stall_cnt, bubble_cnt) are compiled in with PIPE_STAGE_PERF_EN.
module pipe_stage_hs #(
  parameter int DATAPATH_WIDTH  = 64,
  parameter int INST_ADDR_WIDTH = 9,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATAPATH_WIDTH-1:0]  inst_in,
  input  logic [INST_ADDR_WIDTH-1:0] pc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATAPATH_WIDTH-1:0]  inst_out,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output logic [CNT_WIDTH-1:0]       bubble_cnt,
`endif
  output logic [INST_ADDR_WIDTH-1:0] pc_out
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;

  state_e                       state_q, state_d;
  logic [DATAPATH_WIDTH-1:0]    main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [INST_ADDR_WIDTH-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic                         in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    main_inst_q <= main_inst_d;
    main_pc_q   <= main_pc_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (reset || flush) begin
      state_d     = EMPTY;
      main_inst_d = '0;
      main_pc_d   = '0;
      skid_inst_d = '0;
      skid_pc_d   = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          main_inst_d = inst_in;
          main_pc_d   = pc_in;
          state_d     = FULL;
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_inst_d = inst_in;
            main_pc_d   = pc_in;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            skid_inst_d = inst_in;
            skid_pc_d   = pc_in;
            state_d     = SKID;
          end
        end
        SKID: if (out_ready) begin
          main_inst_d = skid_inst_q;
          main_pc_d   = skid_pc_q;
          state_d     = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready decodes state only, so there is no comb path from out_ready.
  always_comb begin
    in_ready  = !reset && (state_q != SKID);
    out_valid = (state_q != EMPTY);
    inst_out  = main_inst_q;
    pc_out    = main_pc_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_ff @(posedge clk) begin
    stall_cnt_q  <= stall_cnt_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  // Saturating; flush does not clear them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (reset) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (!out_valid && !(&bubble_cnt_q))             bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  wire unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: per-cycle vector table, hand sequences and a FIFO scoreboard.
module tb_pipe_stage_hs;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] inst_in, inst_out;
  logic [AW-1:0] pc_in, pc_out;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  pipe_stage_hs #(.DATAPATH_WIDTH(DW), .INST_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, fl, iv;
    logic [DW-1:0] inst;
    logic [AW-1:0] pc;
    logic ordy;
    logic e_ov, e_ir;
    logic [DW-1:0] e_inst;
    logic [AW-1:0] e_pc;
  } vec_t;

  typedef struct { logic [DW-1:0] inst; logic [AW-1:0] pc; } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  logic was_in_xfer;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample handshakes just before the edge, update the scoreboard, then step past the edge.
  task automatic cyc();
    logic ix, ox;
    item_t it;
    #1;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (ox) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", {55'd0, pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        it = sb.pop_front();
        chk("sb_inst", inst_out, it.inst);
        chk("sb_pc", {55'd0, pc_out}, {55'd0, it.pc});
      end
    end
    if (reset || flush) sb.delete();
    else if (ix) sb.push_back('{inst_in, pc_in});
    was_in_xfer = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] d, input logic [AW-1:0] p, input logic ordy);
    reset = r; flush = f; in_valid = iv; inst_in = d; pc_in = p; out_ready = ordy;
  endtask

  vec_t vt[22];

  initial begin
    drive(1, 0, 0, '0, '0, 0);
    //            rst fl iv inst      pc  ordy ov ir e_inst    e_pc
    vt[0]  = '{1, 0, 1, 64'hDEAD, 0, 0, 0, 0, 64'h0,  0};
    vt[1]  = '{1, 0, 1, 64'hDEAD, 0, 0, 0, 0, 64'h0,  0};
    vt[2]  = '{0, 0, 1, 64'h11,   1, 1, 1, 1, 64'h11, 1};
    vt[3]  = '{0, 0, 1, 64'h22,   2, 1, 1, 1, 64'h22, 2};
    vt[4]  = '{0, 0, 1, 64'h33,   3, 1, 1, 1, 64'h33, 3};
    vt[5]  = '{0, 0, 0, 64'h0,    0, 1, 0, 1, 64'h33, 3};
    vt[6]  = '{0, 0, 1, 64'hA0,   4, 0, 1, 1, 64'hA0, 4};
    vt[7]  = '{0, 0, 1, 64'hB0,   5, 0, 1, 0, 64'hA0, 4};
    vt[8]  = '{0, 0, 1, 64'hB0,   5, 0, 1, 0, 64'hA0, 4};
    vt[9]  = '{0, 0, 0, 64'h0,    0, 1, 1, 1, 64'hB0, 5};
    vt[10] = '{0, 0, 0, 64'h0,    0, 1, 0, 1, 64'hB0, 5};
    vt[11] = '{0, 0, 1, 64'hD1,   6, 0, 1, 1, 64'hD1, 6};
    vt[12] = '{0, 0, 1, 64'hD2,   7, 0, 1, 0, 64'hD1, 6};
    vt[13] = '{0, 1, 1, 64'hC0,   8, 0, 0, 1, 64'h0,  0};
    vt[14] = '{0, 0, 0, 64'h0,    0, 1, 0, 1, 64'h0,  0};
    vt[15] = '{0, 0, 1, 64'h55,   9, 0, 1, 1, 64'h55, 9};
    vt[16] = '{1, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,  0};
    vt[17] = '{0, 0, 0, 64'h0,    0, 1, 0, 1, 64'h0,  0};
    vt[18] = '{0, 0, 1, 64'h66,  10, 1, 1, 1, 64'h66, 10};
    vt[19] = '{0, 1, 1, 64'h77,  11, 1, 0, 1, 64'h0,  0};
    vt[20] = '{0, 0, 1, 64'h88,  12, 1, 1, 1, 64'h88, 12};
    vt[21] = '{0, 0, 0, 64'h0,    0, 1, 0, 1, 64'h88, 12};

    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].inst, vt[i].pc, vt[i].ordy);
      cyc();
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].e_ir});
      chk($sformatf("v%0d_inst_out", i), inst_out, vt[i].e_inst);
      chk($sformatf("v%0d_pc_out", i), {55'd0, pc_out}, {55'd0, vt[i].e_pc});
    end
    chk("sb_empty_after_table", sb.size(), 0);

    // in_ready rises as soon as reset drops, before any edge.
    drive(1, 0, 1, 64'hDEAD, 0, 0);
    cyc();
    chk("ir_in_reset", {63'd0, in_ready}, 0);
    reset = 1'b0;
    #1;
    chk("ir_after_release", {63'd0, in_ready}, 1);

    // Random traffic with occasional flush; data held stable while stalled.
    in_valid = 1'b0;
    was_in_xfer = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid || was_in_xfer || flush) begin
        in_valid = ($urandom_range(0, 3) != 0);
        inst_in  = {$urandom, $urandom};
        pc_in    = AW'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      cyc();
    end
    drive(0, 0, 0, '0, '0, 1);
    for (int n = 0; n < 4; n++) cyc();
    chk("sb_drained", sb.size(), 0);
    chk("drained_out_valid", {63'd0, out_valid}, 0);

`ifdef PIPE_STAGE_PERF_EN
    drive(1, 0, 0, '0, '0, 0);
    cyc();
    chk("cnt_reset_stall", stall_cnt, 0);
    chk("cnt_reset_bubble", bubble_cnt, 0);
    drive(0, 0, 1, 64'h99, 1, 0);
    cyc();
    in_valid = 1'b0;
    for (int n = 0; n < 20; n++) cyc();
    chk("stall_sat", stall_cnt, 15);
    chk("bubble_one", bubble_cnt, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_keeps_stall", stall_cnt, 15);
    chk("flush_keeps_bubble", bubble_cnt, 1);
    drive(1, 0, 0, '0, '0, 0);
    cyc();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) cyc();
    chk("bubble_three", bubble_cnt, 3);
    chk("stall_zero", stall_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised handshaked pipeline stage register for the fetch/decode boundary and any later stage boundary in the core. It carries an instruction word and its PC from an upstream producer to a downstream consumer using valid/ready flow control, with a one-entry skid buffer so `in_ready` never depends combinationally on `out_ready`. It supports a synchronous flush for branch redirects and, optionally, performance counters.

## Interface
- `DATAPATH_WIDTH`, 64: instruction word width.
- `INST_ADDR_WIDTH`, 9: PC width.
- `CNT_WIDTH`, 16: perf counter width; used only with `PIPE_STAGE_PERF_EN`.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: upstream holds valid inst/pc.
- `in_ready` out 1: stage can accept this cycle.
- `inst_in` in DATAPATH_WIDTH: instruction in.
- `pc_in` in INST_ADDR_WIDTH: PC in.
- `out_valid` out 1: `inst_out`/`pc_out` valid.
- `out_ready` in 1: downstream accepts.
- `inst_out` out DATAPATH_WIDTH: registered instruction.
- `pc_out` out INST_ADDR_WIDTH: registered PC.
- `stall_cnt` out CNT_WIDTH: present only with `PIPE_STAGE_PERF_EN`.
- `bubble_cnt` out CNT_WIDTH: present only with `PIPE_STAGE_PERF_EN`.

## Operation
- Storage:
  - Main register (drives outputs) plus one skid register (`skid_inst`, `skid_pc`).
  - State encoded as EMPTY / FULL / SKID.
- Handshakes:
  - In-transfer = `in_valid & in_ready`.
  - Out-transfer = `out_valid & out_ready`.
- `in_ready = !reset && state != SKID`. This is a decode of the state register only, with no path from `out_ready`.
- `out_valid = (state != EMPTY)`.
- Transitions when neither reset nor flush is active:
  - EMPTY: on in-transfer, main ← input, go to FULL. Otherwise hold.
  - FULL, out-transfer and in-transfer: main ← input, stay in FULL.
  - FULL, out-transfer only: go to EMPTY. Main data is retained but invalid.
  - FULL, in-transfer only: skid ← input, go to SKID.
  - FULL, neither: hold.
  - SKID, `out_ready`: main ← skid, go to FULL. No input is accepted because `in_ready=0`.
  - SKID, `!out_ready`: hold.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- Flush:
  - Priority order is reset > flush > handshake.
  - Next state is EMPTY; `inst_out` ← 0 and `pc_out` ← 0; skid contents are discarded.
  - An in-transfer in the flush cycle is dropped.
  - An out-transfer in the flush cycle still counts as completed by downstream.
- Upstream protocol: upstream must hold `inst_in`/`pc_in` stable while `in_valid & !in_ready`. The stage does not check this.

## Timing
- Reset values:
  - state EMPTY, `out_valid=0`, `inst_out=0`, `pc_out=0`.
  - `in_ready=0` while `reset` is high; 1 on the first cycle after reset.
  - Counters are 0.
- Latency: an in-transfer at edge N gives `out_valid=1` with that data after edge N, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained while `out_ready=1`.
- Backpressure:
  - `in_ready` falls one cycle after the first stalled cycle that accepted an input, i.e. on entry to SKID.
  - At most one extra beat is absorbed.
- Reset or flush mid-SKID: both entries are lost and `in_ready=1` on the next cycle (for flush; for reset, once reset deasserts).

## Configuration
- `PIPE_STAGE_PERF_EN` defined: `stall_cnt` and `bubble_cnt` ports and logic are compiled in.
  - `stall_cnt` increments each cycle `out_valid & !out_ready`.
  - `bubble_cnt` increments each cycle `!out_valid`.
  - Both saturate at all-ones, clear only on `reset` (not on `flush`), and do not count in reset cycles.
- `PIPE_STAGE_PERF_EN` undefined: the ports are absent and no counter logic exists. Datapath behaviour is identical either way.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid=1`, `inst_in=0xDEAD` → `out_valid=0`, `inst_out=0`, `pc_out=0`, `in_ready=0`. After release `in_ready=1`.
- Streaming: `out_ready=1`, present inst 0x11/0x22/0x33 with pc 1/2/3 on consecutive cycles → outputs appear 1 cycle later, back-to-back, in order, `in_ready` stays 1.
- Skid: `out_ready=0`, send 0xA0 (pc 4) then 0xB0 (pc 5) → `out_valid=1` with 0xA0, `in_ready=0` after the second accept. Raise `out_ready` → 0xA0 then 0xB0 delivered, `in_ready=1` after 0xA0 leaves.
- Flush in SKID with `in_valid=1`, `inst_in=0xC0` → next cycle `out_valid=0`, `inst_out=0`, `pc_out=0`, `in_ready=1`. 0xC0 and the skid entry never appear at the output.
- Reset mid-stream (state FULL, `inst_out=0x55`) → next cycle all outputs 0, state EMPTY.
- With `PIPE_STAGE_PERF_EN` and `CNT_WIDTH=4`: 20 cycles of `out_valid=1`, `out_ready=0` → `stall_cnt=15` (saturated); 3 idle cycles → `bubble_cnt=3`. A flush leaves both counts unchanged.
